// File: rtl/cpu_trace_checker.sv
// Byte-serial parser/checker for "^time@pc: $reg <= data#" and "^time@pc: *addr <= data#" trace lines.
// Latency: format_type pulses for one cycle, in the cycle after the terminating '#' is sampled.
// No backpressure: one character is consumed every clock; fields and flags hold until the next good line.
module cpu_trace_checker #(
  parameter int          TIME_MAX_DIGITS = 4,
  parameter int          REG_MAX_DIGITS  = 4,
  parameter bit          CHECK_EN        = 1'b1,
  parameter logic [31:0] PC_MIN          = 32'h0000_3000,
  parameter logic [31:0] PC_MAX          = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_MIN        = 32'h0000_0000,
  parameter logic [31:0] ADDR_MAX        = 32'h0000_2ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  output logic [1:0]  format_type,
  output logic [3:0]  err_flags,
  output logic [31:0] time_q,
  output logic [31:0] pc_q,
  output logic [31:0] addr_q,
  output logic [31:0] data_q,
  output logic [15:0] line_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_REG, S_ADDR,
    S_SP2, S_LT, S_SP3, S_DATA, S_HASH, S_DONE
  } state_t;

  localparam logic [3:0] TIME_LIM = 4'(TIME_MAX_DIGITS);
  localparam logic [3:0] REG_LIM  = 4'(REG_MAX_DIGITS);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] time_sh, time_nx;
  logic [31:0] pc_sh, pc_nx;
  logic [31:0] addr_sh, addr_nx;   // register number (decimal) or memory address (hex)
  logic [31:0] data_sh, data_nx;
  logic        is_mem, is_mem_nx;
  logic [31:0] prev_time;
  logic        line_done;
  logic        is_dec, is_hex;
  logic [3:0]  dig;
  logic [3:0]  err_nx;

  // Character classification: decimal digit, lowercase hex digit, and its nibble value.
  always_comb begin
    is_dec = (char >= "0") && (char <= "9");
    is_hex = is_dec || ((char >= "a") && (char <= "f"));
    dig    = 4'h0;
    if (is_dec)      dig = 4'(char - "0");
    else if (is_hex) dig = 4'(char - "a" + 8'd10);
  end

  // Next-state logic: field parsing, shadow accumulation and line completion.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    time_nx   = time_sh;
    pc_nx     = pc_sh;
    addr_nx   = addr_sh;
    data_nx   = data_sh;
    is_mem_nx = is_mem;
    line_done = 1'b0;
    if (char == "^") begin
      // '^' always starts a fresh line, whatever state we were in.
      state_nx  = S_TIME;
      cnt_nx    = 4'd0;
      time_nx   = 32'd0;
      pc_nx     = 32'd0;
      addr_nx   = 32'd0;
      data_nx   = 32'd0;
      is_mem_nx = 1'b0;
    end else begin
      // Any character not handled below drops back to IDLE.
      state_nx = S_IDLE;
      cnt_nx   = 4'd0;
      case (state)
        S_TIME: begin
          if (is_dec && cnt < TIME_LIM) begin
            time_nx  = time_sh * 32'd10 + {28'd0, dig};
            cnt_nx   = cnt + 4'd1;
            state_nx = S_TIME;
          end else if (char == "@" && cnt != 4'd0) begin
            state_nx = S_PC;
          end
        end
        S_PC: begin
          if (is_hex) begin
            pc_nx    = {pc_sh[27:0], dig};
            cnt_nx   = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
            state_nx = (cnt == 4'd7) ? S_COLON : S_PC;
          end
        end
        S_COLON: if (char == ":") state_nx = S_SP1;
        S_SP1: begin
          if (char == " ") state_nx = S_SP1;
          else if (char == "$") begin
            state_nx  = S_REG;
            is_mem_nx = 1'b0;
          end else if (char == "*") begin
            state_nx  = S_ADDR;
            is_mem_nx = 1'b1;
          end
        end
        S_REG: begin
          if (is_dec && cnt < REG_LIM) begin
            addr_nx  = addr_sh * 32'd10 + {28'd0, dig};
            cnt_nx   = cnt + 4'd1;
            state_nx = S_REG;
          end else if (char == " " && cnt != 4'd0) begin
            state_nx = S_SP2;
          end else if (char == "<" && cnt != 4'd0) begin
            state_nx = S_LT;
          end
        end
        S_ADDR: begin
          if (is_hex) begin
            addr_nx  = {addr_sh[27:0], dig};
            cnt_nx   = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
            state_nx = (cnt == 4'd7) ? S_SP2 : S_ADDR;
          end
        end
        S_SP2: begin
          if (char == " ")      state_nx = S_SP2;
          else if (char == "<") state_nx = S_LT;
        end
        S_LT: if (char == "=") state_nx = S_SP3;
        S_SP3: begin
          if (char == " ") state_nx = S_SP3;
          else if (is_hex) begin
            data_nx  = {28'd0, dig};
            cnt_nx   = 4'd1;
            state_nx = S_DATA;
          end
        end
        S_DATA: begin
          if (is_hex) begin
            data_nx  = {data_sh[27:0], dig};
            cnt_nx   = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
            state_nx = (cnt == 4'd7) ? S_HASH : S_DATA;
          end
        end
        S_HASH: begin
          if (char == "#") begin
            state_nx  = S_DONE;
            line_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Error flags for the line completing this cycle; prev_time starts at 0 so bit3 cannot fire on the first line.
  always_comb begin
    err_nx = 4'd0;
    if (CHECK_EN) begin
      err_nx[0] = (pc_sh < PC_MIN) || (pc_sh > PC_MAX) || (pc_sh[1:0] != 2'b00);
      err_nx[1] = !is_mem && (addr_sh > 32'd31);
      err_nx[2] = is_mem && ((addr_sh < ADDR_MIN) || (addr_sh > ADDR_MAX) || (addr_sh[1:0] != 2'b00));
      err_nx[3] = time_sh < prev_time;
    end
  end

  // Line kind is only reported while sitting in DONE.
  always_comb begin
    format_type = 2'b00;
    if (state == S_DONE) format_type = is_mem ? 2'b10 : 2'b01;
  end

  // Parser state, shadows, and result registers loaded on line completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      time_sh   <= 32'd0;
      pc_sh     <= 32'd0;
      addr_sh   <= 32'd0;
      data_sh   <= 32'd0;
      is_mem    <= 1'b0;
      prev_time <= 32'd0;
      err_flags <= 4'd0;
      time_q    <= 32'd0;
      pc_q      <= 32'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      line_cnt  <= 16'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      time_sh <= time_nx;
      pc_sh   <= pc_nx;
      addr_sh <= addr_nx;
      data_sh <= data_nx;
      is_mem  <= is_mem_nx;
      if (line_done) begin
        time_q    <= time_sh;
        pc_q      <= pc_sh;
        addr_q    <= addr_sh;
        data_q    <= data_sh;
        err_flags <= err_nx;
        prev_time <= time_sh;
        if (line_cnt != 16'hffff) line_cnt <= line_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed-vector bench for cpu_trace_checker.
// One character per clock; outputs sampled 1 time unit after each rising edge.
// The DUT never stalls, so no flow control is modelled.
module tb_cpu_trace_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic [3:0]  err_flags;
  logic [31:0] time_q, pc_q, addr_q, data_q;
  logic [15:0] line_cnt;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  logic [1:0] last_fmt = 2'b00;

  cpu_trace_checker dut (
    .clk(clk), .reset(reset), .char(char),
    .format_type(format_type), .err_flags(err_flags),
    .time_q(time_q), .pc_q(pc_q), .addr_q(addr_q), .data_q(data_q),
    .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
    if (format_type != 2'b00) begin
      pulses++;
      last_fmt = format_type;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    char  = " ";
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset  = 1'b0;
    pulses = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    char  = "^";
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (format_type !== 2'b00) begin fails++; $display("FAIL reset_fmt: got %b want 00", format_type); end
    tests++; if (err_flags !== 4'd0) begin fails++; $display("FAIL reset_err: got %b want 0000", err_flags); end
    tests++; if ({time_q, pc_q, addr_q, data_q} !== 128'd0) begin fails++; $display("FAIL reset_fields: got %h %h %h %h want 0", time_q, pc_q, addr_q, data_q); end
    tests++; if (line_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %h want 0", line_cnt); end
    reset  = 1'b0;
    pulses = 0;
  endtask

  task automatic test_reg_line();
    do_reset();
    send_str("^42@00003004: $28 <= ff00ff00#");
    tests++; if (format_type !== 2'b01) begin fails++; $display("FAIL reg_fmt: got %b want 01", format_type); end
    send(" ");
    tests++; if (format_type !== 2'b00 || pulses != 1) begin fails++; $display("FAIL reg_pulse_width: fmt %b pulses %0d want 00 and 1", format_type, pulses); end
    tests++; if (time_q !== 32'd42) begin fails++; $display("FAIL reg_time: got %0d want 42", time_q); end
    tests++; if (pc_q !== 32'h3004) begin fails++; $display("FAIL reg_pc: got %h want 3004", pc_q); end
    tests++; if (addr_q !== 32'd28) begin fails++; $display("FAIL reg_addr: got %0d want 28", addr_q); end
    tests++; if (data_q !== 32'hff00ff00) begin fails++; $display("FAIL reg_data: got %h want ff00ff00", data_q); end
    tests++; if (err_flags !== 4'b0000) begin fails++; $display("FAIL reg_err: got %b want 0000", err_flags); end
    tests++; if (line_cnt !== 16'd1) begin fails++; $display("FAIL reg_cnt: got %0d want 1", line_cnt); end
  endtask

  task automatic test_mem_line();
    do_reset();
    send_str("^7@00003000: *0000100c <=12345678# ");
    tests++; if (pulses != 1 || last_fmt !== 2'b10) begin fails++; $display("FAIL mem_fmt: pulses %0d fmt %b want 1 and 10", pulses, last_fmt); end
    tests++; if (addr_q !== 32'h100c || data_q !== 32'h12345678 || time_q !== 32'd7) begin fails++; $display("FAIL mem_fields: addr %h data %h time %0d want 100c 12345678 7", addr_q, data_q, time_q); end
    tests++; if (err_flags !== 4'b0000) begin fails++; $display("FAIL mem_err: got %b want 0000", err_flags); end
  endtask

  task automatic test_bad_lines();
    // continues from the memory line: outputs must stay at its values
    pulses = 0;
    send_str("^12345@00003000: $1 <= 00000000# ");
    tests++; if (pulses != 0) begin fails++; $display("FAIL long_time_pulse: got %0d pulses want 0", pulses); end
    send_str("^8@00003000: $1 <= 0000000A# ");
    tests++; if (pulses != 0) begin fails++; $display("FAIL upper_hex_pulse: got %0d pulses want 0", pulses); end
    tests++; if (time_q !== 32'd7 || addr_q !== 32'h100c || line_cnt !== 16'd1) begin fails++; $display("FAIL bad_unchanged: time %0d addr %h cnt %0d want 7 100c 1", time_q, addr_q, line_cnt); end
  endtask

  task automatic test_errors();
    do_reset();
    send_str("^50@00003000: $1 <= 00000000# ");
    send_str("^10@00008000: $40 <= 00000001# ");
    tests++; if (pulses != 2 || last_fmt !== 2'b01) begin fails++; $display("FAIL err_reg_fmt: pulses %0d fmt %b want 2 and 01", pulses, last_fmt); end
    tests++; if (err_flags !== 4'b1011) begin fails++; $display("FAIL err_reg_flags: got %b want 1011", err_flags); end
    tests++; if (line_cnt !== 16'd2) begin fails++; $display("FAIL err_cnt: got %0d want 2", line_cnt); end
    send_str("^60@00003002: *00003000 <= 00000000# ");
    tests++; if (err_flags !== 4'b0101) begin fails++; $display("FAIL err_mem_flags: got %b want 0101", err_flags); end
  endtask

  task automatic test_restart();
    do_reset();
    send_str("^1@0000300");
    send_str("^2@00003008: $3 <= 0000000a# ");
    tests++; if (pulses != 1 || time_q !== 32'd2 || pc_q !== 32'h3008 || data_q !== 32'ha) begin fails++; $display("FAIL restart: pulses %0d time %0d pc %h data %h want 1 2 3008 a", pulses, time_q, pc_q, data_q); end
    do_reset();
    send_str("^1@00003000: $3");
    reset = 1'b1;
    send("#");
    reset = 1'b0;
    send_str(" <= 00000001# ");
    tests++; if (pulses != 0 || line_cnt !== 16'd0 || time_q !== 32'd0) begin fails++; $display("FAIL reset_midline: pulses %0d cnt %0d time %0d want 0 0 0", pulses, line_cnt, time_q); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_str("^3@00003000: $1 <= 00000001#^4@00003004: $2 <= 00000002# ");
    tests++; if (pulses != 2 || line_cnt !== 16'd2) begin fails++; $display("FAIL b2b: pulses %0d cnt %0d want 2 2", pulses, line_cnt); end
    tests++; if (time_q !== 32'd4 || addr_q !== 32'd2 || data_q !== 32'd2) begin fails++; $display("FAIL b2b_fields: time %0d addr %0d data %h want 4 2 2", time_q, addr_q, data_q); end
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.line_cnt = 16'hffff;
    @(posedge clk); #1;
    release dut.line_cnt;
    send_str("^9@00003000: $5 <= 00000005# ");
    tests++; if (pulses != 1 || line_cnt !== 16'hffff) begin fails++; $display("FAIL saturate: pulses %0d cnt %h want 1 ffff", pulses, line_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    char  = 8'd0;
    test_reset();
    test_reg_line();
    test_mem_line();
    test_bad_lines();
    test_errors();
    test_restart();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Byte-serial checker for CPU trace lines, one ASCII character per clock. It validates the register-write format "^<time>@<pc>: $<reg> <= <data>#" and the memory-write format "^<time>@<pc>: *<addr> <= <data>#".
- Successor of the fixed-format line checker. Adds a parametrised time field, captured field values, range/alignment/monotonic-time error flags and a valid-line counter.
- Sits between the UART/char source and the trace comparison logic.

Parameters:
TIME_MAX_DIGITS, 4, maximum decimal digits in time field (legal 1..9)
REG_MAX_DIGITS, 4, maximum decimal digits in register field (legal 1..4)
CHECK_EN, 1, 1 = compute err_flags; 0 = err_flags forced to 0
PC_MIN, 32'h0000_3000, lowest legal PC (inclusive)
PC_MAX, 32'h0000_6ffc, highest legal PC (inclusive)
ADDR_MIN, 32'h0000_0000, lowest legal memory address (inclusive)
ADDR_MAX, 32'h0000_2ffc, highest legal memory address (inclusive)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
char  input  8  ASCII character sampled every rising edge
format_type  output  2  00 none, 01 register line, 10 memory line; nonzero for exactly one cycle
err_flags  output  4  [0] PC out of range or PC[1:0]!=0; [1] reg>31; [2] addr out of range or addr[1:0]!=0; [3] time < previous valid line's time
time_q  output  32  binary value of last valid line's time field
pc_q  output  32  PC of last valid line
addr_q  output  32  reg number (zero-extended) or memory address of last valid line
data_q  output  32  data of last valid line
line_cnt  output  16  count of valid lines, saturating at 16'hffff

Behaviour:
- Reset: all outputs 0; FSM in IDLE; digit counter 0; shadow fields 0; prev_time 0. Reset has priority over char.
- Hex digits: lowercase only, '0'-'9' and 'a'-'f'. Decimal digits: '0'-'9'.
- FSM states and transitions:
  - IDLE: '^' -> TIME; anything else stays.
  - TIME: 1..TIME_MAX_DIGITS decimal digits; time_sh = time_sh*10 + digit (mod 2^32); '@' with >=1 digit -> PC.
  - PC: exactly 8 hex digits -> COLON.
  - COLON: ':' -> SP1.
  - SP1: ' ' stays; '$' -> REG; '*' -> ADDR.
  - REG: 1..REG_MAX_DIGITS decimal digits; ' ' -> SP2 or '<' -> LT, either only after >=1 digit.
  - ADDR: exactly 8 hex digits -> SP2.
  - SP2: ' ' stays; '<' -> LT.
  - LT: '=' -> SP3.
  - SP3: ' ' stays; hex digit -> DATA with count 1.
  - DATA: hex digits until 8 total -> HASH.
  - HASH: '#' -> DONE.
  - DONE: '^' -> TIME; else -> IDLE.
- Restart rule: '^' in any state other than IDLE/DONE restarts: -> TIME, counter and shadow fields cleared. Any other illegal char, including a digit beyond its field limit, -> IDLE with counter cleared.
- Shadow fields are cleared on every '^' and accumulate during parsing. Output fields are untouched until a line completes.
- Completion: the edge that samples the terminating '#' loads time_q/pc_q/addr_q/data_q from the shadows and computes err_flags.
  - format_type is nonzero combinationally while FSM = DONE, so latency is exactly 1 cycle after '#' is sampled, for 1 cycle.
  - On the same edge, line_cnt increments (saturating) and prev_time <= time_sh.
- err_flags:
  - Registered with the fields; holds until the next completed line.
  - bit1 only for register lines; bit2 only for memory lines.
  - bit3 is never set on the first valid line after reset.
  - With CHECK_EN=0 all bits are 0.
- Lines with errors still count as valid format: format_type is reported, line_cnt increments, and prev_time updates.
- Back-to-back: "#^" gives format_type pulse in the cycle the '^' is sampled; that '^' starts the next line.
- Reset mid-line: the line is discarded; no pulse, no field or counter update.

Test Plan:
- Reset, then "^42@00003004: $28 <= ff00ff00#" -> format_type=01 for one cycle after '#'; time_q=42, pc_q=0x3004, addr_q=28, data_q=0xff00ff00, err_flags=0, line_cnt=1.
- "^7@00003000: *0000100c <=12345678#" (no space before data) -> format_type=10; addr_q=0x100c, err_flags=0.
- "^12345@00003000: $1 <= 00000000#" with TIME_MAX_DIGITS=4 -> FSM to IDLE at 5th digit; no pulse; outputs unchanged. Also: uppercase hex 'A' in data -> no pulse.
- Line with time 50, then "^10@00008000: $40 <= 00000001#" -> format_type=01, err_flags=4'b1011; line_cnt advances by 2 across both lines.
- "^1@0000300" then "^2@00003008: $3 <= 0000000a#" -> only the second line pulses, time_q=2; "^1@00003000: $3" then reset -> no pulse, line_cnt=0.
- Two lines back-to-back ("...#^...#") -> two one-cycle pulses; line_cnt saturation checked by forcing 16'hffff -> stays 16'hffff.
